// File: rtl/mops_sdo_responder_if.sv
// Request/response frame and ADC fetch signals between the SDO responder and its bus-side neighbours.
// The slave modport is the responder's view; master is the decoder/encoder/ADC side.
interface mops_sdo_responder_if;
    logic [75:0] rx_frame;
    logic        rx_valid;
    logic        rx_ready;
    logic [75:0] tx_frame;
    logic        tx_valid;
    logic        tx_ready;
    logic        adc_req;
    logic [4:0]  adc_ch;
    logic        adc_ack;
    logic [11:0] adc_value;

    modport slave (
        input  rx_frame, rx_valid, tx_ready, adc_ack, adc_value,
        output rx_ready, tx_frame, tx_valid, adc_req, adc_ch
    );

    modport master (
        output rx_frame, rx_valid, tx_ready, adc_ack, adc_value,
        input  rx_ready, tx_frame, tx_valid, adc_req, adc_ch
    );
endinterface

// File: rtl/mops_sdo_responder.sv
// CANopen SDO server for one emulated MOPS node: answers expedited upload requests
// for the device type (0x1000) and ADC channels (0x2400), or replies with an SDO abort.
module mops_sdo_responder #(
    parameter logic [6:0]  NODE_ID      = 7'h01,
    parameter int unsigned ADC_CHANNELS = 32,
    parameter int unsigned ADC_TIMEOUT  = 1023,
    parameter logic [31:0] DEVICE_TYPE  = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    mops_sdo_responder_if.slave         bus,
    output logic [15:0]                 resp_cnt,
    output logic [15:0]                 abort_cnt,
    output logic                        busy
);

    localparam int unsigned TW       = (ADC_TIMEOUT > 1) ? $clog2(ADC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ADC_TIMEOUT - 1);
    localparam logic [8:0]  CH_MAX   = 9'(ADC_CHANNELS);
    localparam logic [10:0] REQ_COB  = 11'h600 + 11'(NODE_ID);
    localparam logic [10:0] RESP_COB = 11'h580 + 11'(NODE_ID);

    localparam logic [7:0]  CMD_UPLOAD_REQ = 8'h40;
    localparam logic [7:0]  CMD_RESP_2B    = 8'h4B;
    localparam logic [7:0]  CMD_RESP_4B    = 8'h43;
    localparam logic [7:0]  CMD_ABORT      = 8'h80;

    localparam logic [31:0] ABORT_BAD_CMD  = 32'h0504_0001;
    localparam logic [31:0] ABORT_NO_OBJ   = 32'h0602_0000;
    localparam logic [31:0] ABORT_BAD_SUB  = 32'h0609_0011;
    localparam logic [31:0] ABORT_HW       = 32'h0800_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ADC_WAIT,
        ST_BUILD,
        ST_SEND
    } state_e;

    state_e         state_q, state_d;
    logic [10:0]    cob_q, cob_d;
    logic           rtr_q, rtr_d;
    logic [7:0]     cmd_q, cmd_d;
    logic [15:0]    index_q, index_d;
    logic [7:0]     sub_q, sub_d;
    logic [7:0]     resp_cmd_q, resp_cmd_d;
    logic [31:0]    value_q, value_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [4:0]     adc_ch_q, adc_ch_d;
    logic           adc_req_q, adc_req_d;
    logic [75:0]    tx_frame_q, tx_frame_d;
    logic           tx_valid_q, tx_valid_d;
    logic           rx_ready_q, rx_ready_d;
    logic           busy_q, busy_d;
    logic [15:0]    resp_cnt_q, resp_cnt_d;
    logic [15:0]    abort_cnt_q, abort_cnt_d;

    // Request bytes 4..7 carry no meaning for an upload request.
    logic unused_rx_bytes;
    assign unused_rx_bytes = ^bus.rx_frame[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cob_q       <= '0;
            rtr_q       <= 1'b0;
            cmd_q       <= '0;
            index_q     <= '0;
            sub_q       <= '0;
            resp_cmd_q  <= '0;
            value_q     <= '0;
            tmo_q       <= '0;
            adc_ch_q    <= '0;
            adc_req_q   <= 1'b0;
            tx_frame_q  <= '0;
            tx_valid_q  <= 1'b0;
            rx_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            resp_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cob_q       <= cob_d;
            rtr_q       <= rtr_d;
            cmd_q       <= cmd_d;
            index_q     <= index_d;
            sub_q       <= sub_d;
            resp_cmd_q  <= resp_cmd_d;
            value_q     <= value_d;
            tmo_q       <= tmo_d;
            adc_ch_q    <= adc_ch_d;
            adc_req_q   <= adc_req_d;
            tx_frame_q  <= tx_frame_d;
            tx_valid_q  <= tx_valid_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
            resp_cnt_q  <= resp_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cob_d       = cob_q;
        rtr_d       = rtr_q;
        cmd_d       = cmd_q;
        index_d     = index_q;
        sub_d       = sub_q;
        resp_cmd_d  = resp_cmd_q;
        value_d     = value_q;
        tmo_d       = tmo_q;
        adc_ch_d    = adc_ch_q;
        tx_frame_d  = tx_frame_q;
        tx_valid_d  = tx_valid_q;
        resp_cnt_d  = resp_cnt_q;
        abort_cnt_d = abort_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid && rx_ready_q) begin
                    cob_d   = bus.rx_frame[75:65];
                    rtr_d   = bus.rx_frame[64];
                    cmd_d   = bus.rx_frame[63:56];
                    index_d = {bus.rx_frame[47:40], bus.rx_frame[55:48]};
                    sub_d   = bus.rx_frame[39:32];
                    state_d = ST_DECODE;
                end
            end

            // Frames for other nodes or remote requests are silently dropped.
            ST_DECODE: begin
                if (cob_q != REQ_COB || rtr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_BUILD;
                    resp_cmd_d = CMD_ABORT;
                    if (cmd_q != CMD_UPLOAD_REQ) begin
                        value_d = ABORT_BAD_CMD;
                    end else if (index_q == 16'h1000) begin
                        if (sub_q == 8'd0) begin
                            resp_cmd_d = CMD_RESP_4B;
                            value_d    = DEVICE_TYPE;
                        end else begin
                            value_d = ABORT_BAD_SUB;
                        end
                    end else if (index_q == 16'h2400) begin
                        if (sub_q != 8'd0 && {1'b0, sub_q} <= CH_MAX) begin
                            state_d  = ST_ADC_WAIT;
                            adc_ch_d = 5'(sub_q - 8'd1);
                            tmo_d    = '0;
                        end else begin
                            value_d = ABORT_BAD_SUB;
                        end
                    end else begin
                        value_d = ABORT_NO_OBJ;
                    end
                end
            end

            // An acknowledge arriving on the final timeout cycle still wins.
            ST_ADC_WAIT: begin
                if (bus.adc_ack) begin
                    resp_cmd_d = CMD_RESP_2B;
                    value_d    = {20'd0, bus.adc_value};
                    state_d    = ST_BUILD;
                end else if (tmo_q == TMO_LAST) begin
                    resp_cmd_d = CMD_ABORT;
                    value_d    = ABORT_HW;
                    state_d    = ST_BUILD;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ST_BUILD: begin
                tx_frame_d = {RESP_COB, 1'b0, resp_cmd_q,
                              index_q[7:0], index_q[15:8], sub_q,
                              value_q[7:0], value_q[15:8], value_q[23:16], value_q[31:24]};
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end

            ST_SEND: begin
                if (bus.tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                    if (resp_cmd_q == CMD_ABORT) begin
                        if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
                    end else begin
                        if (resp_cnt_q != 16'hFFFF) resp_cnt_d = resp_cnt_q + 16'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        adc_req_d  = (state_d == ST_ADC_WAIT);
        rx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_frame = tx_frame_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.adc_req  = adc_req_q;
    assign bus.adc_ch   = adc_ch_q;
    assign resp_cnt     = resp_cnt_q;
    assign abort_cnt    = abort_cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mops_sdo_responder.sv
// Self-checking bench for mops_sdo_responder: expected response frames are queued
// when each request is driven and compared by a monitor at every tx transfer.
module tb_mops_sdo_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] resp_cnt;
    logic [15:0] abort_cnt;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_resp   = 0;
    int m_abort  = 0;
    logic [75:0] exp_q[$];
    logic [75:0] mon_exp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mops_sdo_responder_if bus_if ();

    mops_sdo_responder #(
        .NODE_ID      (7'h01),
        .ADC_CHANNELS (32),
        .ADC_TIMEOUT  (15),
        .DEVICE_TYPE  (32'h0004_0191)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .resp_cnt  (resp_cnt),
        .abort_cnt (abort_cnt),
        .busy      (busy)
    );

    function automatic logic [75:0] resp(input logic [63:0] data);
        return {11'h581, 1'b0, data};
    endfunction

    // Scoreboard monitor: sampled shortly after the falling edge, once inputs have settled.
    always @(negedge clk) begin
        #2;
        if (!rst && bus_if.tx_valid && bus_if.tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_tx got=%h expected=none", bus_if.tx_frame);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus_if.tx_frame !== mon_exp) begin
                    failures++;
                    $display("FAIL tx_frame got=%h expected=%h", bus_if.tx_frame, mon_exp);
                end
                if (mon_exp[63:56] == 8'h80) m_abort++;
                else m_resp++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_req(input logic [10:0] cob, input logic rtr, input logic [63:0] data,
                            output int t0);
        t0 = -1;
        bus_if.rx_frame = {cob, rtr, data};
        bus_if.rx_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            if (bus_if.rx_ready) begin
                t0 = cyc;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int budget, output int t, output int req_cycles);
        t = -1;
        req_cycles = 0;
        for (int k = 0; k < budget; k++) begin
            if (bus_if.tx_valid) begin
                t = cyc;
                break;
            end
            if (bus_if.adc_req) req_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic wait_adc_req(input int budget, output int t);
        t = -1;
        for (int k = 0; k < budget; k++) begin
            if (bus_if.adc_req) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64 && bus_if.tx_valid; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus_if.rx_ready !== 1'b1) begin failures++; $display("FAIL reset_rx_ready got=%b expected=1", bus_if.rx_ready); end
        checks++; if (bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b expected=0", bus_if.tx_valid); end
        checks++; if (bus_if.tx_frame !== 76'd0) begin failures++; $display("FAIL reset_tx_frame got=%h expected=0", bus_if.tx_frame); end
        checks++; if (bus_if.adc_req !== 1'b0) begin failures++; $display("FAIL reset_adc_req got=%b expected=0", bus_if.adc_req); end
        checks++; if (bus_if.adc_ch !== 5'd0) begin failures++; $display("FAIL reset_adc_ch got=%0d expected=0", bus_if.adc_ch); end
        checks++; if (resp_cnt !== 16'd0 || abort_cnt !== 16'd0) begin failures++; $display("FAIL reset_counters got=%0d/%0d expected=0/0", resp_cnt, abort_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b expected=0", busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_adc_read();
        int t0, tr, t, n, a;
        exp_q.push_back(resp(64'h4B00_2405_BC0A_0000));
        send_req(11'h601, 1'b0, 64'h4000_2405_0000_0000, t0);
        wait_adc_req(32, tr);
        checks++; if (tr - t0 != 2) begin failures++; $display("FAIL adc_req_latency got=%0d expected=2", tr - t0); end
        checks++; if (bus_if.adc_ch !== 5'd4) begin failures++; $display("FAIL adc_ch_read got=%0d expected=4", bus_if.adc_ch); end
        repeat (5) tick();
        checks++; if (bus_if.adc_req !== 1'b1) begin failures++; $display("FAIL adc_req_held got=%b expected=1", bus_if.adc_req); end
        bus_if.adc_value = 12'hABC;
        bus_if.adc_ack   = 1'b1;
        a = cyc;
        tick();
        bus_if.adc_ack   = 1'b0;
        bus_if.adc_value = 12'h000;
        checks++; if (bus_if.adc_req !== 1'b0) begin failures++; $display("FAIL adc_req_drop got=%b expected=0", bus_if.adc_req); end
        wait_tx(32, t, n);
        checks++; if (t - a != 2) begin failures++; $display("FAIL ack_to_tx_latency got=%0d expected=2", t - a); end
        wait_idle();
        checks++; if (resp_cnt !== 16'd1 || abort_cnt !== 16'd0) begin failures++; $display("FAIL adc_read_counters got=%0d/%0d expected=1/0", resp_cnt, abort_cnt); end
    endtask

    task automatic test_unknown_index();
        int t0, t, n;
        exp_q.push_back(resp(64'h8034_1200_0000_0206));
        send_req(11'h601, 1'b0, 64'h4034_1200_0000_0000, t0);
        wait_tx(32, t, n);
        checks++; if (t - t0 != 3) begin failures++; $display("FAIL unknown_idx_latency got=%0d expected=3", t - t0); end
        checks++; if (n != 0) begin failures++; $display("FAIL unknown_idx_adc_req got=%0d expected=0", n); end
        wait_idle();
        checks++; if (abort_cnt !== 16'(m_abort) || resp_cnt !== 16'(m_resp)) begin failures++; $display("FAIL unknown_idx_counters got=%0d/%0d expected=%0d/%0d", resp_cnt, abort_cnt, m_resp, m_abort); end
    endtask

    task automatic test_device_type();
        int t0, t, n;
        exp_q.push_back(resp(64'h4300_1000_9101_0400));
        send_req(11'h601, 1'b0, 64'h4000_1000_0000_0000, t0);
        wait_tx(32, t, n);
        checks++; if (t - t0 != 3) begin failures++; $display("FAIL devtype_latency got=%0d expected=3", t - t0); end
        wait_idle();
        checks++; if (resp_cnt !== 16'(m_resp)) begin failures++; $display("FAIL devtype_resp_cnt got=%0d expected=%0d", resp_cnt, m_resp); end
    endtask

    task automatic test_drop_and_sub();
        int t0, t, n, seen;
        send_req(11'h602, 1'b0, 64'h4000_2401_0000_0000, t0);
        checks++; if (bus_if.rx_ready !== 1'b0) begin failures++; $display("FAIL drop_rx_ready_n1 got=%b expected=0", bus_if.rx_ready); end
        tick();
        checks++; if (bus_if.rx_ready !== 1'b1 || cyc - t0 != 2) begin failures++; $display("FAIL drop_rx_ready_n2 got=%b expected=1", bus_if.rx_ready); end
        send_req(11'h601, 1'b1, 64'h4000_2401_0000_0000, t0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus_if.tx_valid || bus_if.adc_req) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL drop_activity got=%0d expected=0", seen); end
        checks++; if (resp_cnt !== 16'(m_resp) || abort_cnt !== 16'(m_abort)) begin failures++; $display("FAIL drop_counters got=%0d/%0d expected=%0d/%0d", resp_cnt, abort_cnt, m_resp, m_abort); end
        exp_q.push_back(resp(64'h8000_2400_1100_0906));
        send_req(11'h601, 1'b0, 64'h4000_2400_0000_0000, t0);
        wait_tx(32, t, n);
        checks++; if (t - t0 != 3) begin failures++; $display("FAIL sub0_latency got=%0d expected=3", t - t0); end
        wait_idle();
        exp_q.push_back(resp(64'h8000_2421_1100_0906));
        send_req(11'h601, 1'b0, 64'h4000_2421_0000_0000, t0);
        wait_tx(32, t, n);
        checks++; if (n != 0) begin failures++; $display("FAIL sub33_adc_req got=%0d expected=0", n); end
        wait_idle();
        exp_q.push_back(resp(64'h8000_2401_0100_0405));
        send_req(11'h601, 1'b0, 64'h2F00_2401_0000_0000, t0);
        wait_tx(32, t, n);
        wait_idle();
        checks++; if (abort_cnt !== 16'(m_abort)) begin failures++; $display("FAIL abort_cnt got=%0d expected=%0d", abort_cnt, m_abort); end
    endtask

    task automatic test_timeout();
        int t0, t, n, seen;
        exp_q.push_back(resp(64'h8000_2401_0000_0008));
        send_req(11'h601, 1'b0, 64'h4000_2401_0000_0000, t0);
        wait_tx(100, t, n);
        checks++; if (n != 15) begin failures++; $display("FAIL timeout_req_cycles got=%0d expected=15", n); end
        checks++; if (t - t0 != 18) begin failures++; $display("FAIL timeout_latency got=%0d expected=18", t - t0); end
        wait_idle();
        bus_if.adc_value = 12'hFFF;
        bus_if.adc_ack   = 1'b1;
        tick();
        bus_if.adc_ack   = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus_if.tx_valid || bus_if.adc_req || busy) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL late_ack_activity got=%0d expected=0", seen); end
        checks++; if (resp_cnt !== 16'(m_resp) || abort_cnt !== 16'(m_abort)) begin failures++; $display("FAIL late_ack_counters got=%0d/%0d expected=%0d/%0d", resp_cnt, abort_cnt, m_resp, m_abort); end
    endtask

    task automatic test_back_to_back();
        int t0, tr, t, n;
        exp_q.push_back(resp(64'h4B00_2420_2301_0000));
        send_req(11'h601, 1'b0, 64'h4000_2420_0000_0000, t0);
        wait_adc_req(32, tr);
        bus_if.adc_value = 12'h123;
        bus_if.adc_ack   = 1'b1;
        checks++; if (bus_if.adc_ch !== 5'd31) begin failures++; $display("FAIL adc_ch_top got=%0d expected=31", bus_if.adc_ch); end
        tick();
        bus_if.adc_ack = 1'b0;
        wait_tx(32, t, n);
        checks++; if (t - t0 != 4) begin failures++; $display("FAIL fast_ack_latency got=%0d expected=4", t - t0); end
        wait_idle();
        exp_q.push_back(resp(64'h8099_9900_0000_0206));
        send_req(11'h601, 1'b0, 64'h4099_9900_0000_0000, t0);
        wait_tx(32, t, n);
        checks++; if (t - t0 != 3) begin failures++; $display("FAIL b2b_latency got=%0d expected=3", t - t0); end
        wait_idle();
    endtask

    task automatic test_backpressure();
        int t0, tr, t, n, bad, xfer, acc;
        logic [75:0] snap;
        bus_if.tx_ready = 1'b0;
        exp_q.push_back(resp(64'h4B00_2402_FF0F_0000));
        send_req(11'h601, 1'b0, 64'h4000_2402_0000_0000, t0);
        wait_adc_req(32, tr);
        bus_if.adc_value = 12'hFFF;
        bus_if.adc_ack   = 1'b1;
        tick();
        bus_if.adc_ack = 1'b0;
        wait_tx(32, t, n);
        snap = bus_if.tx_frame;
        bus_if.rx_frame = {11'h601, 1'b0, 64'h4055_5500_0000_0000};
        bus_if.rx_valid = 1'b1;
        exp_q.push_back(resp(64'h8055_5500_0000_0206));
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus_if.tx_valid !== 1'b1 || bus_if.tx_frame !== snap || bus_if.rx_ready !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL backpressure_hold got=%0d bad cycles expected=0", bad); end
        checks++; if (snap !== resp(64'h4B00_2402_FF0F_0000)) begin failures++; $display("FAIL backpressure_frame got=%h", snap); end
        bus_if.tx_ready = 1'b1;
        xfer = cyc;
        acc  = -1;
        tick();
        for (int k = 0; k < 20; k++) begin
            if (bus_if.rx_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        tick();
        bus_if.rx_valid = 1'b0;
        checks++; if (acc != xfer + 1) begin failures++; $display("FAIL second_accept_cycle got=%0d expected=%0d", acc, xfer + 1); end
        wait_tx(32, t, n);
        wait_idle();
        checks++; if (resp_cnt !== 16'(m_resp) || abort_cnt !== 16'(m_abort)) begin failures++; $display("FAIL backpressure_counters got=%0d/%0d expected=%0d/%0d", resp_cnt, abort_cnt, m_resp, m_abort); end
    endtask

    task automatic test_reset_mid();
        int t0, tr, seen;
        send_req(11'h601, 1'b0, 64'h4000_2403_0000_0000, t0);
        wait_adc_req(32, tr);
        rst = 1'b1;
        tick();
        m_resp  = 0;
        m_abort = 0;
        checks++; if (bus_if.adc_req !== 1'b0 || bus_if.tx_valid !== 1'b0) begin failures++; $display("FAIL midreset_outputs got=%b%b expected=00", bus_if.adc_req, bus_if.tx_valid); end
        checks++; if (bus_if.rx_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL midreset_ready got=%b busy=%b expected=1/0", bus_if.rx_ready, busy); end
        checks++; if (resp_cnt !== 16'd0 || abort_cnt !== 16'd0) begin failures++; $display("FAIL midreset_counters got=%0d/%0d expected=0/0", resp_cnt, abort_cnt); end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus_if.tx_valid || bus_if.adc_req) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_stale got=%0d expected=0", seen); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size()); end
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.rx_frame  = '0;
        bus_if.rx_valid  = 1'b0;
        bus_if.tx_ready  = 1'b1;
        bus_if.adc_ack   = 1'b0;
        bus_if.adc_value = '0;
        tick();
        test_reset();
        test_adc_read();
        test_unknown_index();
        test_device_type();
        test_drop_and_sub();
        test_timeout();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
